// File: rtl/ahb2apb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb2apb_arb_pkg
//  Description : Shared types and constants for the two-requester AHB-lite
//                arbiter that fronts the AHB-to-APB bridge.
//                - arb_state_t : transfer FSM state encoding
//                - HTRANS_*    : AHB transfer-type codes used by the arbiter
//                - HSIZE_WORD  : the only transfer size issued (32-bit)
//                - idx_onehot  : requester index -> one-hot requester mask
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb2apb_arb_pkg;

    // Transfer FSM: one address phase, one data phase, then back to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // Requester index (0/1) to the one-hot mask used on ack and grant.
    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb2apb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb2apb_arbiter_if
//  Description : AHB-lite link between the arbiter (master) and the
//                AHB-to-APB bridge (slave).
//                master : drives hsel, haddr, hwrite, hsize, htrans, hwdata;
//                         samples hready, hrdata, hresp
//                slave  : the mirror image
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb2apb_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [1:0]        htrans;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic [DATA_W-1:0] hrdata;
    logic              hresp;

    modport master (
        output hsel, haddr, hwrite, hsize, htrans, hwdata,
        input  hready, hrdata, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, htrans, hwdata,
        output hready, hrdata, hresp
    );

endinterface
`default_nettype wire

// File: rtl/ahb2apb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ahb2apb_rr_pick
//  Description : Two-way round-robin winner selection.
//                A lone request wins outright; on contention the requester
//                that was not granted last wins.
//  Ports       : req        in  2  eligible requests (bit i = requester i)
//                last_grant in  1  index of the requester served last
//                grant      out 2  one-hot winner, 0 when nobody requests
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb2apb_rr_pick (
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    output logic      [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ahb2apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ahb2apb_arbiter
//  Description : Arbitrates two requesters onto a single AHB-lite master port
//                feeding an AHB-to-APB bridge. One single (NONSEQ) transfer
//                at a time, no pipelining: IDLE -> ADDR -> DATA -> IDLE.
//  Ports       : hclk      in   1       clock, rising edge
//                hreset_n  in   1       asynchronous active-low reset
//                req       in   2       per-requester request, held to ack
//                m*_addr   in   ADDR_W  requester address
//                m*_write  in   1       requester direction, 1 = write
//                m*_wdata  in   DATA_W  requester write data
//                ack       out  2       one-cycle completion pulse
//                rdata     out  DATA_W  read data, valid with ack
//                err       out  1       hresp of completed transfer, with ack
//                bus       master modport of ahb2apb_arbiter_if
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb2apb_arbiter
    import ahb2apb_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              hclk,
    input  wire logic              hreset_n,
    input  wire logic [1:0]        req,
    input  wire logic [ADDR_W-1:0] m0_addr,
    input  wire logic [ADDR_W-1:0] m1_addr,
    input  wire logic              m0_write,
    input  wire logic              m1_write,
    input  wire logic [DATA_W-1:0] m0_wdata,
    input  wire logic [DATA_W-1:0] m1_wdata,
    output logic      [1:0]        ack,
    output logic      [DATA_W-1:0] rdata,
    output logic                   err,
    ahb2apb_arbiter_if.master      bus
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;

    logic              r_owner;      // requester of the transfer in flight
    logic              r_last;       // requester served by the last completion
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [1:0]        w_eligible;
    logic [1:0]        w_grant;
    logic              w_start;
    logic              w_done;

    // A requester that is being acked this cycle may still show req high
    // (it reacts to ack a cycle late); masking it stops a phantom re-grant.
    assign w_eligible = req & ~r_ack;

    ahb2apb_rr_pick u_pick (
        .req        (w_eligible),
        .last_grant (r_last),
        .grant      (w_grant)
    );

    // ------------------------------------------------------------------
    // Next state and bus outputs. Address-phase signals are only driven in
    // ADDR so the bus reads quiet (and all-zero under reset) otherwise.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        bus.hsel    = 1'b0;
        bus.htrans  = HTRANS_IDLE;
        bus.hsize   = 3'b000;
        bus.hwrite  = 1'b0;
        bus.haddr   = '0;

        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus.hsel   = 1'b1;
                bus.htrans = HTRANS_NONSEQ;
                bus.hsize  = HSIZE_WORD;
                bus.haddr  = r_addr;
                bus.hwrite = r_write;
                if (bus.hready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.hready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latched write data is presented for the whole data phase.
    assign bus.hwdata = r_wdata;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Requester inputs are captured once, at grant; later changes on the
    // requester side cannot disturb the transfer in flight.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_owner <= w_grant[1];
            r_addr  <= w_grant[1] ? m1_addr  : m0_addr;
            r_write <= w_grant[1] ? m1_write : m0_write;
            r_wdata <= w_grant[1] ? m1_wdata : m0_wdata;
        end
    end

    // Completion: response registered, ack pulsed one cycle, pointer moved.
    // Reset starts the pointer at requester 1 so requester 0 wins first.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_ack   <= 2'b00;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_ack <= 2'b00;
            if (w_done) begin
                r_ack   <= idx_onehot(r_owner);
                r_rdata <= bus.hrdata;
                r_err   <= bus.hresp;
                r_last  <= r_owner;
            end
        end
    end

    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb2apb_arbiter
//  Description : Self-checking bench for ahb2apb_arbiter. Directed scenarios
//                followed by a randomized run checked against a transaction
//                level model of the arbitration and bus-phase rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_arbiter;

    logic        hclk     = 1'b0;
    logic        hreset_n = 1'b1;
    logic [1:0]  req      = 2'b00;
    logic [31:0] m0_addr  = '0;
    logic [31:0] m1_addr  = '0;
    logic        m0_write = 1'b0;
    logic        m1_write = 1'b0;
    logic [31:0] m0_wdata = '0;
    logic [31:0] m1_wdata = '0;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    ahb2apb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb2apb_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .req      (req),
        .m0_addr  (m0_addr),
        .m1_addr  (m1_addr),
        .m0_write (m0_write),
        .m1_write (m1_write),
        .m0_wdata (m0_wdata),
        .m1_wdata (m1_wdata),
        .ack      (ack),
        .rdata    (rdata),
        .err      (err),
        .bus      (bus.master)
    );

    always #5 hclk = ~hclk;

    // Advance one clock; outputs are read 1 ns after the rising edge.
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        bus.hready = 1'b1; bus.hrdata = '0; bus.hresp = 1'b0;
        #1 hreset_n = 1'b0;
        #2;
        n_cmp++; if (bus.htrans !== 2'b00) begin n_bad++; $display("FAIL reset htrans: got %b want 00", bus.htrans); end
        n_cmp++; if (bus.hsel !== 1'b0) begin n_bad++; $display("FAIL reset hsel: got %b want 0", bus.hsel); end
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL reset ack: got %b want 00", ack); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset rdata: got %h want 0", rdata); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b want 0", err); end
        n_cmp++; if (bus.haddr !== 32'h0) begin n_bad++; $display("FAIL reset haddr: got %h want 0", bus.haddr); end
        n_cmp++; if (bus.hwdata !== 32'h0) begin n_bad++; $display("FAIL reset hwdata: got %h want 0", bus.hwdata); end
        n_cmp++; if (bus.hwrite !== 1'b0) begin n_bad++; $display("FAIL reset hwrite: got %b want 0", bus.hwrite); end
        n_cmp++; if (bus.hsize !== 3'b000) begin n_bad++; $display("FAIL reset hsize: got %b want 000", bus.hsize); end
        // Requests and clocks while held in reset must not start anything.
        req = 2'b11;
        tick();
        tick();
        n_cmp++; if (bus.htrans !== 2'b00) begin n_bad++; $display("FAIL reset_held htrans: got %b want 00", bus.htrans); end
        n_cmp++; if (bus.hsel !== 1'b0) begin n_bad++; $display("FAIL reset_held hsel: got %b want 0", bus.hsel); end
        req = 2'b00;
        hreset_n = 1'b1;
    endtask

    task automatic test_contention();
        req = 2'b11; m0_addr = 32'h100; m1_addr = 32'h200;
        m0_write = 1'b0; m1_write = 1'b0; bus.hready = 1'b1; bus.hrdata = 32'h0BAD_0001;
        tick(); // address phase of first winner
        n_cmp++; if (bus.haddr !== 32'h100) begin n_bad++; $display("FAIL contention first_addr: got %h want 100", bus.haddr); end
        n_cmp++; if (bus.htrans !== 2'b10) begin n_bad++; $display("FAIL contention first_htrans: got %b want 10", bus.htrans); end
        tick();
        tick();
        n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL contention first_ack: got %b want 01", ack); end
        tick(); // req still 11 through the ack cycle
        n_cmp++; if (bus.haddr !== 32'h200) begin n_bad++; $display("FAIL contention second_addr: got %h want 200", bus.haddr); end
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL contention ack_gap: got %b want 00", ack); end
        req = 2'b10;
        tick();
        tick();
        n_cmp++; if (ack !== 2'b10) begin n_bad++; $display("FAIL contention second_ack: got %b want 10", ack); end
        tick(); // req[1] held through its ack cycle must not re-grant
        n_cmp++; if (bus.htrans !== 2'b00) begin n_bad++; $display("FAIL contention masked_htrans: got %b want 00", bus.htrans); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_single_write();
        req = 2'b01; m0_addr = 32'h0000_0010; m0_wdata = 32'hA5A5_A5A5; m0_write = 1'b1;
        bus.hready = 1'b1; bus.hresp = 1'b0;
        tick();
        n_cmp++; if (bus.htrans !== 2'b10) begin n_bad++; $display("FAIL single htrans: got %b want 10", bus.htrans); end
        n_cmp++; if (bus.haddr !== 32'h10) begin n_bad++; $display("FAIL single haddr: got %h want 10", bus.haddr); end
        n_cmp++; if (bus.hwrite !== 1'b1) begin n_bad++; $display("FAIL single hwrite: got %b want 1", bus.hwrite); end
        n_cmp++; if (bus.hsel !== 1'b1) begin n_bad++; $display("FAIL single hsel: got %b want 1", bus.hsel); end
        n_cmp++; if (bus.hsize !== 3'b010) begin n_bad++; $display("FAIL single hsize: got %b want 010", bus.hsize); end
        tick();
        n_cmp++; if (bus.htrans !== 2'b00) begin n_bad++; $display("FAIL single data_htrans: got %b want 00", bus.htrans); end
        n_cmp++; if (bus.hwdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL single hwdata: got %h want a5a5a5a5", bus.hwdata); end
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL single early_ack: got %b want 00", ack); end
        tick();
        n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL single ack: got %b want 01", ack); end
        req = 2'b00;
        tick();
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL single ack_pulse: got %b want 00", ack); end
    endtask

    task automatic test_wait_read();
        req = 2'b10; m1_addr = 32'h300; m1_write = 1'b0; bus.hready = 1'b1;
        tick(); // cycle 1: address phase
        n_cmp++; if (bus.haddr !== 32'h300 || bus.hwrite !== 1'b0) begin n_bad++; $display("FAIL wait addr_phase: got %h/%b want 300/0", bus.haddr, bus.hwrite); end
        tick(); // cycle 2: data phase
        bus.hready = 1'b0;
        tick(); // cycle 3
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL wait ack_c3: got %b want 00", ack); end
        tick(); // cycle 4
        n_cmp++; if (ack !== 2'b00 || bus.htrans !== 2'b00) begin n_bad++; $display("FAIL wait c4: got ack %b htrans %b want 00/00", ack, bus.htrans); end
        bus.hready = 1'b1; bus.hrdata = 32'h1234_5678; bus.hresp = 1'b0;
        tick(); // cycle 5
        n_cmp++; if (ack !== 2'b10) begin n_bad++; $display("FAIL wait ack: got %b want 10", ack); end
        n_cmp++; if (rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL wait rdata: got %h want 12345678", rdata); end
        req = 2'b00; bus.hrdata = 32'h0;
        tick();
    endtask

    task automatic test_error();
        req = 2'b01; m0_addr = 32'h40; m0_write = 1'b1; bus.hready = 1'b1; bus.hresp = 1'b0;
        tick();
        tick();
        bus.hresp = 1'b1; bus.hrdata = 32'hDEAD_BEEF;
        tick();
        n_cmp++; if (ack !== 2'b01 || err !== 1'b1) begin n_bad++; $display("FAIL error err_set: got ack %b err %b want 01/1", ack, err); end
        req = 2'b00; bus.hresp = 1'b0;
        tick();
        req = 2'b01; m0_addr = 32'h44;
        tick();
        tick();
        tick();
        n_cmp++; if (ack !== 2'b01 || err !== 1'b0) begin n_bad++; $display("FAIL error err_clear: got ack %b err %b want 01/0", ack, err); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset_midop();
        req = 2'b10; m1_addr = 32'h500; m1_write = 1'b1; m1_wdata = 32'h5555_0000;
        bus.hready = 1'b1; bus.hrdata = 32'hCAFE_0000;
        tick(); // address phase
        tick(); // data phase
        bus.hready = 1'b0;
        #2 hreset_n = 1'b0;
        #1;
        n_cmp++; if (bus.htrans !== 2'b00 || bus.hsel !== 1'b0) begin n_bad++; $display("FAIL midreset bus: got htrans %b hsel %b want 00/0", bus.htrans, bus.hsel); end
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL midreset ack: got %b want 00", ack); end
        n_cmp++; if (rdata !== 32'h0 || err !== 1'b0) begin n_bad++; $display("FAIL midreset resp: got %h/%b want 0/0", rdata, err); end
        n_cmp++; if (bus.hwdata !== 32'h0) begin n_bad++; $display("FAIL midreset hwdata: got %h want 0", bus.hwdata); end
        bus.hready = 1'b1;
        tick();
        hreset_n = 1'b1;
        req = 2'b11; m0_addr = 32'h600; m0_write = 1'b0;
        tick();
        n_cmp++; if (bus.haddr !== 32'h600 || ack !== 2'b00) begin n_bad++; $display("FAIL midreset regrant: got haddr %h ack %b want 600/00", bus.haddr, ack); end
        tick();
        tick();
        n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL midreset ack_after: got %b want 01", ack); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_early_drop();
        req = 2'b01; m0_addr = 32'h700; m0_write = 1'b1; bus.hready = 1'b1;
        tick(); // address phase
        req = 2'b00;
        tick();
        tick();
        n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL early_drop ack: got %b want 01", ack); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (bus.htrans !== 2'b00 || ack !== 2'b00) begin n_bad++; $display("FAIL early_drop idle%0d: got htrans %b ack %b want 00/00", k, bus.htrans, ack); end
        end
    endtask

    // Randomized run. Model: requesters post transactions and hold req until
    // ack (sometimes one cycle past it); the bridge answers with random
    // hready/hrdata/hresp. The model tracks the bus phase at transaction
    // level and predicts winner, address phase, data phase and completion.
    task automatic test_random(input int ncyc);
        int          phase;      // 0 idle, 1 address phase, 2 data phase
        int          owner;
        int          last_srv;
        logic [1:0]  exp_ack;
        logic [1:0]  req_prev;
        logic [1:0]  ack_prev;
        logic [1:0]  elig;
        logic        hr_prev;
        logic        hp_prev;
        logic [31:0] hd_prev;
        logic [31:0] want_addr [2];
        logic [31:0] want_wdata [2];
        logic        want_write [2];
        logic [31:0] cur_addr;
        logic [31:0] cur_wdata;
        logic        cur_write;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        late [2];

        phase = 0; owner = 0; last_srv = 1; exp_ack = 2'b00;
        cur_addr = '0; cur_wdata = '0; cur_write = 1'b0; exp_rdata = '0; exp_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            want_addr[i] = '0; want_wdata[i] = '0; want_write[i] = 1'b0; late[i] = 1'b0;
        end
        req = 2'b00;
        hreset_n = 1'b0;
        #2 hreset_n = 1'b1;
        tick();

        for (int c = 0; c < ncyc; c++) begin
            bus.hready = ($urandom_range(3) != 0);
            bus.hrdata = $urandom;
            bus.hresp  = ($urandom_range(4) == 0);
            req_prev = req; ack_prev = exp_ack;
            hr_prev = bus.hready; hd_prev = bus.hrdata; hp_prev = bus.hresp;
            tick();

            exp_ack = 2'b00;
            if (phase == 0) begin
                elig = req_prev & ~ack_prev;
                if (elig != 2'b00) begin
                    if (elig == 2'b11) owner = (last_srv == 0) ? 1 : 0;
                    else               owner = elig[1] ? 1 : 0;
                    cur_addr = want_addr[owner]; cur_wdata = want_wdata[owner]; cur_write = want_write[owner];
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (hr_prev) phase = 2;
            end else begin
                if (hr_prev) begin
                    exp_ack = (owner == 1) ? 2'b10 : 2'b01;
                    exp_rdata = hd_prev; exp_err = hp_prev; last_srv = owner; phase = 0;
                end
            end

            n_cmp++; if (ack !== exp_ack) begin n_bad++; $display("FAIL rand ack c%0d: got %b want %b", c, ack, exp_ack); end
            if (phase == 1) begin
                n_cmp++;
                if (bus.htrans !== 2'b10 || bus.hsel !== 1'b1 || bus.hsize !== 3'b010 ||
                    bus.haddr !== cur_addr || bus.hwrite !== cur_write) begin
                    n_bad++;
                    $display("FAIL rand addr_phase c%0d: got %b/%b/%b/%h/%b want 10/1/010/%h/%b",
                             c, bus.htrans, bus.hsel, bus.hsize, bus.haddr, bus.hwrite, cur_addr, cur_write);
                end
            end else begin
                n_cmp++; if (bus.htrans !== 2'b00 || bus.hsel !== 1'b0) begin n_bad++; $display("FAIL rand idle_bus c%0d: got %b/%b want 00/0", c, bus.htrans, bus.hsel); end
            end
            if (phase == 2) begin
                n_cmp++; if (bus.hwdata !== cur_wdata) begin n_bad++; $display("FAIL rand hwdata c%0d: got %h want %h", c, bus.hwdata, cur_wdata); end
            end
            if (exp_ack != 2'b00) begin
                n_cmp++; if (rdata !== exp_rdata || err !== exp_err) begin n_bad++; $display("FAIL rand resp c%0d: got %h/%b want %h/%b", c, rdata, err, exp_rdata, exp_err); end
            end

            for (int i = 0; i < 2; i++) begin
                if (exp_ack[i]) begin
                    if ($urandom_range(1) == 1) req[i] = 1'b0;
                    else                        late[i] = 1'b1;
                end else if (late[i]) begin
                    req[i] = 1'b0; late[i] = 1'b0;
                end else if (!req[i] && $urandom_range(2) == 0) begin
                    want_addr[i] = $urandom; want_wdata[i] = $urandom; want_write[i] = ($urandom_range(1) == 1);
                    if (i == 0) begin m0_addr = want_addr[0]; m0_wdata = want_wdata[0]; m0_write = want_write[0]; end
                    else        begin m1_addr = want_addr[1]; m1_wdata = want_wdata[1]; m1_write = want_write[1]; end
                    req[i] = 1'b1;
                end
            end
            // The winner's inputs may wander once its transfer is in flight.
            if (phase != 0 && $urandom_range(1) == 1) begin
                if (owner == 0) begin m0_addr = $urandom; m0_wdata = $urandom; m0_write = ~m0_write; end
                else            begin m1_addr = $urandom; m1_wdata = $urandom; m1_write = ~m1_write; end
            end
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_wait_read();
        test_error();
        test_reset_midop();
        test_early_drop();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
